// File: rtl/data_mem_ctrl.sv
// Data memory controller: turns one load/store request from the execute/memory
// stage into a single handshaked bus transaction. It formats load data by size
// and sign, generates store byte enables and lane-replicated write data, and
// stalls the pipeline until the access completes, faults or times out.
module data_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,  // 0 disables the request timeout
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // Request from the control unit / execute stage
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    // Pipeline side results
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misaligned,
    output logic              err,
    // Data memory bus
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_err
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Access size field (funct3[1:0]) shared by loads and stores
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Load encodings that need sign/zero handling
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Timeout counter only needs to reach TIMEOUT_CYCLES-1: the abort fires
    // on the edge that would complete the TIMEOUT_CYCLES-th unacked cycle.
    localparam int              CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              LP_TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] LP_TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_funct3;      // access type of the transaction in flight
    logic [1:0]        r_lane;        // byte lane of the transaction in flight
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [31:0]       r_bus_wdata;
    logic [3:0]        r_bus_be;
    logic [31:0]       r_rdata;
    logic              r_rdata_valid;
    logic              r_misaligned;
    logic              r_err;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic              w_request;
    logic              w_f3_legal;
    logic              w_illegal;
    logic              w_misaligned;
    logic              w_accept;
    logic [3:0]        w_store_be;
    logic [31:0]       w_store_wdata;
    logic [7:0]        w_load_byte;
    logic [15:0]       w_load_half;
    logic [31:0]       w_load_data;

    assign w_request = mem_read | mem_write;

    // Classify the incoming request: illegal encoding first, then alignment.
    // NOTE: every signal gets a default at the top of an always_comb so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_f3_legal   = 1'b0;
        w_misaligned = 1'b0;
        if (mem_read) begin
            w_f3_legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        end else begin
            w_f3_legal = funct3 inside {F3_LB, F3_LH, F3_LW};
        end
        w_illegal = (mem_read & mem_write) | ~w_f3_legal;
        if (funct3[1:0] == SZ_HALF) begin
            w_misaligned = addr[0];
        end else if (funct3[1:0] == SZ_WORD) begin
            w_misaligned = (addr[1:0] != 2'b00);
        end
    end

    // A request is taken onto the bus only from IDLE and only when legal.
    assign w_accept = (r_state == ST_IDLE) & w_request & ~w_illegal & ~w_misaligned;

    // Stall is combinational so the accepting cycle already holds the pipe.
    assign stall = (r_state == ST_REQ) | w_accept;

    // Build store byte enables and lane-replicated write data; loads read all lanes.
    always_comb begin
        w_store_be    = 4'b1111;
        w_store_wdata = 32'h0000_0000;
        if (!mem_read) begin
            case (funct3[1:0])
                SZ_BYTE: begin
                    w_store_be    = 4'b0001 << addr[1:0];
                    w_store_wdata = {4{wdata[7:0]}};
                end
                SZ_HALF: begin
                    w_store_be    = addr[1] ? 4'b1100 : 4'b0011;
                    w_store_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    w_store_be    = 4'b1111;
                    w_store_wdata = wdata;
                end
            endcase
        end
    end

    // Extract the addressed byte/half of the returned word and extend it.
    always_comb begin
        case (r_lane)
            2'd0:    w_load_byte = bus_rdata[7:0];
            2'd1:    w_load_byte = bus_rdata[15:8];
            2'd2:    w_load_byte = bus_rdata[23:16];
            default: w_load_byte = bus_rdata[31:24];
        endcase
        w_load_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_funct3)
            F3_LB:   w_load_data = {{24{w_load_byte[7]}}, w_load_byte};
            F3_LBU:  w_load_data = {24'h00_0000, w_load_byte};
            F3_LH:   w_load_data = {{16{w_load_half[15]}}, w_load_half};
            F3_LHU:  w_load_data = {16'h0000, w_load_half};
            default: w_load_data = bus_rdata;
        endcase
    end

    // Transaction FSM: accept in IDLE, hold the bus in REQ, release in DONE.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_funct3      <= 3'b000;
            r_lane        <= 2'b00;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= 32'h0000_0000;
            r_bus_be      <= 4'b0000;
            r_rdata       <= 32'h0000_0000;
            r_rdata_valid <= 1'b0;
            r_misaligned  <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            // Result flags are single-cycle pulses unless re-asserted below.
            r_rdata_valid <= 1'b0;
            r_misaligned  <= 1'b0;
            r_err         <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_request) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else if (w_misaligned) begin
                            r_misaligned <= 1'b1;
                        end else begin
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= mem_write;
                            r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            r_bus_wdata <= w_store_wdata;
                            r_bus_be    <= w_store_be;
                            r_funct3    <= funct3;
                            r_lane      <= addr[1:0];
                            r_cnt       <= '0;
                            r_state     <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (bus_err) begin
                            r_err <= 1'b1;
                        end else if (!r_bus_we) begin
                            r_rdata       <= w_load_data;
                            r_rdata_valid <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end else if (LP_TO_EN && (r_cnt == LP_TO_LAST)) begin
                        r_bus_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    // Inputs here still belong to the finished instruction.
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_bus_req <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign misaligned  = r_misaligned;
    assign err         = r_err;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign bus_be      = r_bus_be;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: directed scenarios with literal expectations,
// then randomized load/store traffic compared every cycle against a
// transaction-level reference model kept in this file.
module tb_data_mem_ctrl;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misaligned;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    data_mem_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .ADDR_W        (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .misaligned (misaligned),
        .err        (err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters and expected per-cycle outputs
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 0;
    logic        exp_stall, exp_rv, exp_err, exp_mis, exp_bus_req, exp_bus_we;
    logic [31:0] exp_rdata, exp_bus_addr, exp_bus_wdata;
    logic [3:0]  exp_bus_be;

    // Observation counters for directed checks
    int          n_req_hi, n_rv, n_err, n_mis, n_stall;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model helpers ----------------
    // 0 = no request, 1 = illegal, 2 = misaligned, 3 = bus access
    function automatic int classify(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
        bit legal;
        if (!rd && !wr) return 0;
        if (rd && wr) return 1;
        legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        if (!legal) return 1;
        if ((f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0)) return 2;
        return 3;
    endfunction

    function automatic logic [3:0] model_be(bit rd, logic [2:0] f3, logic [31:0] a);
        if (rd) return 4'hF;
        case (f3[1:0])
            2'd0:    return 4'(1 << a[1:0]);
            2'd1:    return 4'(3 << (2 * a[1]));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wd(bit rd, logic [2:0] f3, logic [31:0] wd);
        if (rd) return 32'h0;
        case (f3[1:0])
            2'd0:    return (wd & 32'hFF) * 32'h0101_0101;
            2'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] fmt_load(logic [2:0] f3, logic [1:0] lane, logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * lane)) & 32'hFF;
        h = (w >> (16 * lane[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // ---------------- per-cycle compare and monitor ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", stall, exp_stall);
            check("bus_req", bus_req, exp_bus_req);
            check("rdata_valid", rdata_valid, exp_rv);
            check("err", err, exp_err);
            check("misaligned", misaligned, exp_mis);
            check("rdata", rdata, exp_rdata);
            if (exp_bus_req) begin
                check("bus_we", bus_we, exp_bus_we);
                check("bus_addr", bus_addr, exp_bus_addr);
                check("bus_be", bus_be, exp_bus_be);
                check("bus_wdata", bus_wdata, exp_bus_wdata);
            end
            if (bus_req) begin
                n_req_hi++;
                cap_addr = bus_addr;
                cap_wd   = bus_wdata;
                cap_be   = bus_be;
                cap_we   = bus_we;
            end
            if (rdata_valid) n_rv++;
            if (err)         n_err++;
            if (misaligned)  n_mis++;
            if (stall)       n_stall++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_req_hi = 0; n_rv = 0; n_err = 0; n_mis = 0; n_stall = 0;
    endtask

    // Bus noise for cycles where bus_req is low: must be ignored.
    task automatic stray();
        bus_ack   = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
        bus_err   = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        exp_stall = 1'b0;
        for (int i = 0; i < n; i++) begin
            stray();
            tick();
            exp_rv = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
        end
    endtask

    // One instruction's memory access. ack_after: REQ cycle (1-based) in which
    // the bus acks; 0 or > TO means no ack (timeout).
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_after, input logic [31:0] brd, input bit berr);
        int cls;
        bit acked;
        cls       = classify(rd, wr, f3, a);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        stray();
        exp_stall = (cls == 3);
        tick();
        exp_rv  = 1'b0;
        exp_err = (cls == 1);
        exp_mis = (cls == 2);
        if (cls != 3) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            exp_stall = 1'b0;
            return;
        end
        exp_bus_req   = 1'b1;
        exp_bus_we    = wr;
        exp_bus_addr  = a & ~32'd3;
        exp_bus_be    = model_be(rd, f3, a);
        exp_bus_wdata = model_wd(rd, f3, wd);
        acked = 1'b0;
        for (int k = 1; k <= TO && !acked; k++) begin
            acked     = (k == ack_after);
            bus_ack   = acked;
            bus_rdata = acked ? brd : $urandom;
            bus_err   = acked ? berr : 1'($urandom_range(0, 1));
            tick();
            exp_rv = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
        end
        // Completion cycle: pipeline released, result flags visible
        exp_bus_req = 1'b0;
        exp_stall   = 1'b0;
        if (acked) begin
            exp_err = berr;
            exp_rv  = !berr && rd;
            if (exp_rv) exp_rdata = fmt_load(f3, a[1:0], brd);
        end else begin
            exp_err = 1'b1;
        end
        mem_read  = 1'($urandom_range(0, 1));
        mem_write = 1'($urandom_range(0, 1));
        funct3    = 3'($urandom_range(0, 7));
        addr      = $urandom;
        stray();
        tick();
        exp_rv = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // ---------------- time limit ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
        exp_stall = 1'b0; exp_rv = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
        exp_bus_req = 1'b0; exp_bus_we = 1'b0; exp_rdata = 32'h0;
        exp_bus_addr = 32'h0; exp_bus_wdata = 32'h0; exp_bus_be = 4'h0;
        clr();
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_stall", stall, 1'b0);
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_bus_we", bus_we, 1'b0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_be", bus_be, 4'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_pulses", {rdata_valid, err, misaligned}, 3'b000);
        chk_en = 1'b1;
        idle(1);

        // LW 0x100, ack in the third request cycle
        clr();
        access(1, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 0);
        check("lw_req_cycles", n_req_hi, 3);
        check("lw_bus_addr", cap_addr, 32'h100);
        check("lw_stall_cycles", n_stall, 4);
        check("lw_rv_pulses", n_rv, 1);
        check("lw_rdata", rdata, 32'hDEAD_BEEF);

        // Sub-word loads
        access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_FFFF, 0);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        access(1, 0, 3'b100, 32'h103, 32'h0, 2, 32'h80FF_FFFF, 0);
        check("lbu_rdata", rdata, 32'h0000_0080);
        access(1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h8001_0000, 0);
        check("lh_rdata", rdata, 32'hFFFF_8001);

        // Stores
        access(0, 1, 3'b000, 32'h201, 32'h1234_56AB, 2, $urandom, 0);
        check("sb_be", cap_be, 4'b0010);
        check("sb_wdata", cap_wd, 32'hABAB_ABAB);
        check("sb_we", cap_we, 1'b1);
        check("sb_addr", cap_addr, 32'h200);
        access(0, 1, 3'b001, 32'h202, 32'h1234_56AB, 1, $urandom, 0);
        check("sh_be", cap_be, 4'b1100);
        check("sh_wdata", cap_wd, 32'h56AB_56AB);

        // Rejected requests
        clr();
        access(1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0, 0);
        idle(1);
        check("mis_pulses", n_mis, 1);
        check("mis_no_req", n_req_hi, 0);
        check("mis_no_stall", n_stall, 0);
        clr();
        access(1, 1, 3'b010, 32'h100, 32'h0, 1, 32'h0, 0);
        idle(1);
        check("both_err", n_err, 1);
        check("both_no_req", n_req_hi, 0);
        clr();
        access(1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 0);
        idle(1);
        check("f3_err", n_err, 1);
        check("f3_no_req", n_req_hi, 0);

        // Timeout and bus error
        clr();
        access(1, 0, 3'b010, 32'h180, 32'h0, 0, 32'h0, 0);
        check("to_req_cycles", n_req_hi, TO);
        check("to_err", n_err, 1);
        check("to_stall_cycles", n_stall, TO + 1);
        clr();
        access(1, 0, 3'b010, 32'h184, 32'h0, 2, 32'h5555_5555, 1);
        check("berr_err", n_err, 1);
        check("berr_no_rv", n_rv, 0);
        check("berr_rdata_held", rdata, 32'hFFFF_8001);

        // Reset in the middle of a transaction, then a late ack
        clr();
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
        stray();
        exp_stall = 1'b1;
        tick();
        exp_bus_req = 1'b1; exp_bus_we = 1'b0; exp_bus_addr = 32'h300;
        exp_bus_be = 4'hF; exp_bus_wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = $urandom;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_read = 1'b0;
        exp_bus_req = 1'b0; exp_stall = 1'b0; exp_rdata = 32'h0;
        bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0; bus_err = 1'b0;
        tick();
        bus_ack = 1'b0;
        tick();
        check("rst_mid_req_cycles", n_req_hi, 2);
        check("rst_mid_bus_req", bus_req, 1'b0);
        check("rst_mid_no_rv", n_rv, 0);
        check("rst_mid_rdata", rdata, 32'h0);
        access(1, 0, 3'b010, 32'h104, 32'h0, 2, 32'h0BAD_F00D, 0);
        check("post_rst_lw", rdata, 32'h0BAD_F00D);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r, r2, ack_after;
            bit rd, wr;
            r = $urandom_range(0, 15);
            rd = (r == 1) || (r >= 2 && r <= 8);
            wr = (r == 1) || (r > 8);
            r2 = $urandom_range(0, 19);
            ack_after = (r2 == 0) ? 0 : (r2 == 1) ? TO : $urandom_range(1, 4);
            access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   ack_after, $urandom, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(2);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
